// File: rtl/cpu_register_bank_if.sv
// Memory-side bus of the register bank's bulk-transfer sequencer.
// The master (register bank) issues one request at a time and holds it
// until the slave (data memory) answers with mem_ready.
interface cpu_register_bank_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 12
);
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;
   logic              mem_re;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   modport master (
      output mem_addr,
      output mem_wdata,
      output mem_we,
      output mem_re,
      input  mem_rdata,
      input  mem_ready
   );

   modport slave (
      input  mem_addr,
      input  mem_wdata,
      input  mem_we,
      input  mem_re,
      output mem_rdata,
      output mem_ready
   );
endinterface

// File: rtl/cpu_register_bank.sv
// General-purpose register file with combinational Vx/Vy/flag reads, one
// host write port plus a dedicated flag write, and a sequencer that copies
// V0..Vlast to or from data memory for the register-range store/load ops.
module cpu_register_bank #(
   parameter int  DATA_W   = 8,
   parameter int  NUM_REGS = 16,
   parameter int  FLAG_IDX = 15,
   parameter int  ADDR_W   = 12,
   localparam int SEL_W    = $clog2(NUM_REGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [SEL_W-1:0]    x,
   input  logic [SEL_W-1:0]    y,
   output logic [DATA_W-1:0]   vx,
   output logic [DATA_W-1:0]   vy,
   output logic [DATA_W-1:0]   vf,
   input  logic                wx,
   input  logic [DATA_W-1:0]   nx,
   input  logic                wf,
   input  logic [DATA_W-1:0]   nf,
   input  logic                bulk_start,
   input  logic                bulk_dir,
   input  logic [SEL_W-1:0]    bulk_last,
   input  logic [ADDR_W-1:0]   bulk_base,
   output logic                busy,
   output logic                done,
   cpu_register_bank_if.master mem
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                dir_q, dir_d;      // 1 = load registers from memory
   logic [SEL_W-1:0]    last_q, last_d;
   logic [SEL_W-1:0]    idx_q, idx_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   regs_d [NUM_REGS];

   logic                host_we;           // host writes allowed (sequencer not busy)
   logic                load_we;           // memory data lands in Vreg[idx] this cycle

   // Reads come straight from the flops, so loads show up one cycle after mem_ready.
   assign vx = regs_q[x];
   assign vy = regs_q[y];
   assign vf = regs_q[FLAG_IDX];

   // Sequencer next state and bus outputs; requests are a pure function of
   // the latched transfer so they stay stable while memory stalls.
   always_comb begin
      state_d        = state_q;
      dir_d          = dir_q;
      last_d         = last_q;
      idx_d          = idx_q;
      base_d         = base_q;
      host_we        = 1'b0;
      load_we        = 1'b0;
      busy           = 1'b0;
      done           = 1'b0;
      mem.mem_addr   = '0;
      mem.mem_wdata  = '0;
      mem.mem_we     = 1'b0;
      mem.mem_re     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            host_we = 1'b1;
            if (bulk_start) begin
               dir_d   = bulk_dir;
               last_d  = bulk_last;
               base_d  = bulk_base;
               idx_d   = '0;
               state_d = ST_XFER;
            end
         end

         ST_XFER: begin
            busy         = 1'b1;
            mem.mem_addr = base_q + ADDR_W'(idx_q);   // wraps modulo 2^ADDR_W
            if (dir_q) begin
               mem.mem_re = 1'b1;
               load_we    = mem.mem_ready;
            end else begin
               mem.mem_we    = 1'b1;
               mem.mem_wdata = regs_q[idx_q];
            end
            if (mem.mem_ready) begin
               if (idx_q == last_q) begin
                  state_d = ST_DONE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end

         ST_DONE: begin
            // Not busy any more: host writes are accepted, but a new start
            // is only recognised once back in IDLE.
            done    = 1'b1;
            host_we = 1'b1;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Register file next values; flag write is applied after the Vx write so it wins.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_d[i] = regs_q[i];
         if (host_we && wx && (x == SEL_W'(i))) begin
            regs_d[i] = nx;
         end
         if (host_we && wf && (i == FLAG_IDX)) begin
            regs_d[i] = nf;
         end
         if (load_we && (idx_q == SEL_W'(i))) begin
            regs_d[i] = mem.mem_rdata;
         end
      end
   end

   // State and register file flops; reset aborts any transfer and clears all registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         dir_q   <= 1'b0;
         last_q  <= '0;
         idx_q   <= '0;
         base_q  <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         last_q  <= last_d;
         idx_q   <= idx_d;
         base_q  <= base_d;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

endmodule
